// File: rtl/cnn_seq_if.sv
// Command and result-stream bundle between the CNN host and the layer sequencer.
// The host side uses the master modport, the sequencer the slave modport.
interface cnn_seq_if #(
    parameter int WIDTH = 16,
    parameter int COL   = 32,
    parameter int NF_W  = 6
);
    localparam int CW = (COL > 1) ? $clog2(COL) : 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [4:0]       cmd_wdim;
    logic [NF_W-1:0]  cmd_nfilt;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_col;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output cmd_valid, cmd_op, cmd_wdim, cmd_nfilt, out_ready,
        input  cmd_ready, out_data, out_col, out_last, out_valid
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_wdim, cmd_nfilt, out_ready,
        output cmd_ready, out_data, out_col, out_last, out_valid
    );
endinterface

// File: rtl/cnn_layer_seq.sv
// Command-driven layer sequencer: weight load, mapping, convolution, optional pooling, result drain.
// Optional per-phase watchdog enabled by defining CNN_SEQ_TIMEOUT_EN.
module cnn_layer_seq #(
    parameter int WIDTH       = 16,
    parameter int COL         = 32,
    parameter int NF_W        = 6,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 nrst,
    cnn_seq_if.slave             bus,
    output logic [4:0]           wdim,
    output logic                 wload_en,
    input  logic                 wload_done,
    output logic                 map_start,
    input  logic                 map_done,
    output logic                 conv_ce,
    input  logic                 conv_done,
    output logic                 pool_start,
    input  logic                 pool_done,
    input  logic [COL*WIDTH-1:0] sys_data,
    input  logic [COL*WIDTH-1:0] pool_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int CW = (COL > 1) ? $clog2(COL) : 1;

    localparam logic [2:0] OP_CONV      = 3'b001;
    localparam logic [2:0] OP_POOL      = 3'b010;
    localparam logic [2:0] OP_CONV_POOL = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE, S_WLOAD, S_MAP, S_CONV, S_POOL, S_DRAIN
    } state_t;

    state_t           r_state, w_next;
    logic             r_first;
    logic [2:0]       r_op;
    logic [4:0]       r_wdim;
    logic [NF_W-1:0]  r_nfilt;
    logic [NF_W-1:0]  r_pass;
    logic [CW-1:0]    r_col;
    logic             r_done;
    logic             r_err;
    logic [WIDTH-1:0] r_buf [COL];

    logic w_hs, w_illegal, w_acc, w_col_last, w_pass_last, w_finish;
    logic w_cap_sys, w_cap_pool, w_phase_done, w_tmo;

    function automatic logic f_illegal(input logic [2:0] op);
        return !(op == OP_CONV || op == OP_POOL || op == OP_CONV_POOL);
    endfunction

    assign w_hs        = bus.cmd_valid && (r_state == S_IDLE);
    assign w_illegal   = f_illegal(bus.cmd_op);
    assign w_acc       = (r_state == S_DRAIN) && bus.out_ready;
    assign w_col_last  = (r_col == CW'(COL - 1));
    assign w_pass_last = (r_pass == NF_W'(r_nfilt - 1'b1));
    assign w_finish    = w_acc && w_col_last && w_pass_last;

    assign w_phase_done = ((r_state == S_WLOAD) && wload_done) ||
                          ((r_state == S_MAP)   && map_done)   ||
                          ((r_state == S_CONV)  && conv_done)  ||
                          ((r_state == S_POOL)  && pool_done);

`ifdef CNN_SEQ_TIMEOUT_EN
    localparam int PH_W = $clog2(TIMEOUT_CYC + 1);

    logic [PH_W-1:0] r_ph;
    logic            r_sticky;
    logic            w_in_phase;

    assign w_in_phase = (r_state == S_WLOAD) || (r_state == S_MAP) ||
                        (r_state == S_CONV)  || (r_state == S_POOL);
    // A phase done landing on the final watchdog cycle still wins.
    assign w_tmo = w_in_phase && !w_phase_done && (r_ph == PH_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_ph     <= '0;
            r_sticky <= 1'b0;
        end else begin
            if (w_next != r_state)
                r_ph <= '0;
            else if (w_in_phase)
                r_ph <= r_ph + 1'b1;
            r_sticky <= w_tmo || (r_sticky && !w_hs);
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_cap_sys  = 1'b0;
        w_cap_pool = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hs && !w_illegal)
                    w_next = (bus.cmd_op == OP_POOL) ? S_MAP : S_WLOAD;
            end
            S_WLOAD: begin
                if (wload_done)
                    w_next = S_MAP;
            end
            S_MAP: begin
                if (map_done)
                    w_next = (r_op == OP_POOL) ? S_POOL : S_CONV;
            end
            S_CONV: begin
                if (conv_done) begin
                    if (r_op == OP_CONV_POOL) begin
                        w_next = S_POOL;
                    end else begin
                        w_cap_sys = 1'b1;
                        w_next    = S_DRAIN;
                    end
                end
            end
            S_POOL: begin
                if (pool_done) begin
                    w_cap_pool = 1'b1;
                    w_next     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_acc && w_col_last) begin
                    if (w_pass_last)
                        w_next = S_IDLE;
                    else
                        w_next = (r_op == OP_POOL) ? S_MAP : S_WLOAD;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (w_tmo)
            w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_first <= 1'b0;
            r_op    <= '0;
            r_wdim  <= '0;
            r_nfilt <= '0;
            r_pass  <= '0;
            r_col   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            for (int k = 0; k < COL; k++)
                r_buf[k] <= '0;
        end else begin
            r_state <= w_next;
            // Marks the first cycle after any state change for the start strobes.
            r_first <= (w_next != r_state);
            r_done  <= w_finish;
`ifdef CNN_SEQ_TIMEOUT_EN
            r_err   <= w_tmo || (w_hs ? w_illegal : (r_err && r_sticky));
`else
            r_err   <= w_hs && w_illegal;
`endif
            if (w_hs) begin
                r_op    <= bus.cmd_op;
                r_wdim  <= bus.cmd_wdim;
                r_nfilt <= (bus.cmd_nfilt == '0) ? NF_W'(1) : bus.cmd_nfilt;
                r_pass  <= '0;
                r_col   <= '0;
            end
            if (w_acc) begin
                r_col <= w_col_last ? '0 : r_col + 1'b1;
                if (w_col_last && !w_pass_last)
                    r_pass <= r_pass + 1'b1;
            end
            for (int k = 0; k < COL; k++) begin
                if (w_cap_sys)
                    r_buf[k] <= sys_data[k*WIDTH +: WIDTH];
                else if (w_cap_pool)
                    r_buf[k] <= pool_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DRAIN);
    assign bus.out_data  = (r_state == S_DRAIN) ? r_buf[r_col] : '0;
    assign bus.out_col   = r_col;
    assign bus.out_last  = (r_state == S_DRAIN) && w_col_last && w_pass_last;

    assign wdim       = r_wdim;
    assign wload_en   = (r_state == S_WLOAD);
    assign map_start  = (r_state == S_MAP)  && r_first;
    assign conv_ce    = (r_state == S_CONV);
    assign pool_start = (r_state == S_POOL) && r_first;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign err        = r_err;
endmodule

// File: tb/tb_cnn_layer_seq.sv
// Directed scoreboard bench for cnn_layer_seq; honours CNN_SEQ_TIMEOUT_EN with a 16-cycle watchdog.
module tb_cnn_layer_seq;
    localparam int W    = 16;
    localparam int COL  = 32;
    localparam int NF_W = 6;
    localparam int CW   = $clog2(COL);

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]       wdim;
    logic             wload_en, map_start, conv_ce, pool_start;
    logic             wload_done, map_done, conv_done, pool_done;
    logic [COL*W-1:0] sys_data, pool_data;
    logic             busy, done, err;

    cnn_seq_if #(.WIDTH(W), .COL(COL), .NF_W(NF_W)) bus_if ();

    cnn_layer_seq #(.WIDTH(W), .COL(COL), .NF_W(NF_W), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .nrst(nrst), .bus(bus_if.slave),
        .wdim(wdim), .wload_en(wload_en), .wload_done(wload_done),
        .map_start(map_start), .map_done(map_done),
        .conv_ce(conv_ce), .conv_done(conv_done),
        .pool_start(pool_start), .pool_done(pool_done),
        .sys_data(sys_data), .pool_data(pool_data),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [W-1:0]  d;
        logic [CW-1:0] c;
        logic          l;
    } exp_t;

    exp_t q[$];
    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic dsig(input int sel);
        case (sel)
            0:       return wload_en;
            1:       return map_start;
            2:       return conv_ce;
            3:       return pool_start;
            default: return bus_if.out_valid;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (dsig(sel)) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(64'(seen), 64'd1, tag);
    endtask

    task automatic pulse(input int sel);
        case (sel)
            0: wload_done = 1'b1;
            1: map_done   = 1'b1;
            2: conv_done  = 1'b1;
            default: pool_done = 1'b1;
        endcase
        @(negedge clk);
        wload_done = 1'b0; map_done = 1'b0; conv_done = 1'b0; pool_done = 1'b0;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [4:0] wd, input logic [NF_W-1:0] nf);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_op    = op;
        bus_if.cmd_wdim  = wd;
        bus_if.cmd_nfilt = nf;
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
    endtask

    // Drives one pass from WLOAD/MAP entry up to the first DRAIN cycle.
    task automatic do_pass(input logic [2:0] op, input int p, input int nfe);
        exp_t e;
        if (op != 3'b010) begin
            wait_for(0, "wload_en");
            chk(64'(map_start), 64'd0, "map_start_in_wload");
            conv_done = 1'b1; pool_done = 1'b1; map_done = 1'b1;
            @(negedge clk);
            conv_done = 1'b0; pool_done = 1'b0; map_done = 1'b0;
            chk(64'(wload_en), 64'd1, "stray_done_ignored");
            pulse(0);
        end else begin
            chk(64'(wload_en), 64'd0, "wload_skipped");
        end
        wait_for(1, "map_start");
        @(negedge clk);
        chk(64'(map_start), 64'd0, "map_start_one_cycle");
        pulse(1);
        if (op != 3'b010) begin
            wait_for(2, "conv_ce");
            for (int k = 0; k < COL; k++)
                sys_data[k*W +: W] = W'(k + 1 + p * 256);
            if (op == 3'b001) begin
                for (int k = 0; k < COL; k++) begin
                    e.d = W'(k + 1 + p * 256); e.c = CW'(k);
                    e.l = (k == COL - 1) && (p == nfe - 1);
                    q.push_back(e);
                end
            end
            pulse(2);
        end
        if (op != 3'b001) begin
            wait_for(3, "pool_start");
            for (int k = 0; k < COL; k++)
                pool_data[k*W +: W] = W'(16'h8000 + p * 256 + k * 3);
            for (int k = 0; k < COL; k++) begin
                e.d = W'(16'h8000 + p * 256 + k * 3); e.c = CW'(k);
                e.l = (k == COL - 1) && (p == nfe - 1);
                q.push_back(e);
            end
            pulse(3);
        end
        chk(64'(bus_if.out_valid), 64'd1, "first_valid_latency");
    endtask

    // Returns on the negedge whose following posedge accepts the pass's last word.
    task automatic drain_pass(input int mode);
        logic [3:0]    pat = 4'b1001;
        bit            stalled = 1'b0;
        logic [W-1:0]  hd;
        logic [CW-1:0] hc;
        exp_t          e;
        for (int i = 0; i < 400; i++) begin
            logic rdy;
            rdy = (mode == 0) ? 1'b1 : pat[3 - (i % 4)];
            bus_if.out_ready = rdy;
            chk(64'(bus_if.out_valid), 64'd1, "valid_in_drain");
            if (stalled) begin
                chk(64'(bus_if.out_data), 64'(hd), "stall_hold_data");
                chk(64'(bus_if.out_col),  64'(hc), "stall_hold_col");
            end
            if (rdy) begin
                stalled = 1'b0;
                e = q.pop_front();
                chk(64'(bus_if.out_data), 64'(e.d), "out_data");
                chk(64'(bus_if.out_col),  64'(e.c), "out_col");
                chk(64'(bus_if.out_last), 64'(e.l), "out_last");
                if (q.size() == 0)
                    return;
            end else begin
                stalled = 1'b1;
                hd = bus_if.out_data;
                hc = bus_if.out_col;
            end
            @(negedge clk);
        end
        chk(64'(q.size()), 64'd0, "drain_budget");
        q.delete();
    endtask

    task automatic run_layer(input logic [2:0] op, input logic [4:0] wd,
                             input logic [NF_W-1:0] nf, input int mode);
        int nfe = (nf == 0) ? 1 : int'(nf);
        send_cmd(op, wd, nf);
        chk(64'(busy), 64'd1, "busy_after_cmd");
        chk(64'(wdim), 64'(wd), "wdim_latched");
        for (int p = 0; p < nfe; p++) begin
            do_pass(op, p, nfe);
            drain_pass(mode);
            @(negedge clk);
            bus_if.out_ready = 1'b0;
            if (p != nfe - 1)
                chk(64'(done), 64'd0, "no_done_mid_layer");
        end
        chk(64'(done), 64'd1, "done_pulse");
        chk(64'(busy), 64'd0, "idle_after_layer");
        chk(64'(bus_if.cmd_ready), 64'd1, "cmd_ready_after_layer");
        @(negedge clk);
        chk(64'(done), 64'd0, "done_one_cycle");
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bus_if.cmd_valid = 1'b0; bus_if.cmd_op = '0; bus_if.cmd_wdim = '0;
        bus_if.cmd_nfilt = '0;   bus_if.out_ready = 1'b0;
        wload_done = 1'b0; map_done = 1'b0; conv_done = 1'b0; pool_done = 1'b0;
        sys_data = '0; pool_data = '0;

        repeat (3) @(negedge clk);
        chk(64'(bus_if.cmd_ready), 64'd1, "rst_cmd_ready");
        chk(64'(busy),             64'd0, "rst_busy");
        chk(64'(bus_if.out_valid), 64'd0, "rst_out_valid");
        chk(64'(err),              64'd0, "rst_err");
        chk(64'(done),             64'd0, "rst_done");
        chk(64'(wload_en),         64'd0, "rst_wload_en");
        chk(64'(wdim),             64'd0, "rst_wdim");
        nrst = 1'b1;
        @(negedge clk);

        run_layer(3'b001, 5'd3, 6'd1, 0);
        run_layer(3'b011, 5'd5, 6'd2, 0);
        run_layer(3'b010, 5'd7, 6'd0, 0);
        run_layer(3'b001, 5'd9, 6'd1, 1);
        run_layer(3'b010, 5'd2, 6'd2, 1);

        // Abort in the middle of a drain.
        send_cmd(3'b001, 5'd4, 6'd1);
        do_pass(3'b001, 0, 1);
        bus_if.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        q.delete();
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        bus_if.out_ready = 1'b0;
        nrst = 1'b1;
        chk(64'(bus_if.cmd_ready), 64'd1, "abort_cmd_ready");
        chk(64'(bus_if.out_valid), 64'd0, "abort_out_valid");
        chk(64'(busy),             64'd0, "abort_busy");
        chk(64'(done),             64'd0, "abort_no_done");
        @(negedge clk);
        chk(64'(done),             64'd0, "abort_no_done_late");
        chk(64'(bus_if.out_col),   64'd0, "abort_col_clear");

        foreach (q[i]) q.delete(i);
        for (int i = 0; i < 3; i++) begin
            logic [2:0] bad_ops [3];
            bad_ops[0] = 3'b101; bad_ops[1] = 3'b000; bad_ops[2] = 3'b111;
            send_cmd(bad_ops[i], 5'd1, 6'd1);
            chk(64'(err),  64'd1, "illegal_err_pulse");
            chk(64'(busy), 64'd0, "illegal_not_busy");
            @(negedge clk);
            chk(64'(err),  64'd0, "illegal_err_one_cycle");
            chk(64'(busy), 64'd0, "illegal_stays_idle");
        end

        run_layer(3'b001, 5'd1, 6'd1, 0);

        send_cmd(3'b001, 5'd6, 6'd1);
        wait_for(0, "to_wload_en");
        pulse(0);
        wait_for(1, "to_map_start");
        pulse(1);
        wait_for(2, "to_conv_ce");
`ifdef CNN_SEQ_TIMEOUT_EN
        repeat (15) @(negedge clk);
        chk(64'(err),  64'd0, "timeout_not_early");
        chk(64'(busy), 64'd1, "timeout_still_busy");
        @(negedge clk);
        chk(64'(err),  64'd1, "timeout_err");
        chk(64'(busy), 64'd0, "timeout_idle");
        chk(64'(done), 64'd0, "timeout_no_done");
        @(negedge clk);
        chk(64'(err),  64'd1, "timeout_err_sticky");
        send_cmd(3'b010, 5'd1, 6'd1);
        chk(64'(err),  64'd0, "timeout_err_cleared");
`else
        repeat (40) @(negedge clk);
        chk(64'(conv_ce), 64'd1, "no_timeout_conv_ce");
        chk(64'(err),     64'd0, "no_timeout_err");
        chk(64'(busy),    64'd1, "no_timeout_busy");
`endif
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk(64'(busy), 64'd0, "final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
